// File: rtl/wb_stage.sv
// wb_stage: write-back stage; picks the result source, extracts and extends variable-latency load data,
// drives the register-file write port, counts retired instructions and flags misaligned loads.
module wb_stage #(
    parameter bit INSTRET_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_sel,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc4,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        flush,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_write,
    output logic [4:0]  rf_wrAddr,
    output logic [31:0] rf_wrData,
    output logic        misaligned,
    output logic [63:0] instret
);
    typedef enum logic {RUN, WAIT_LD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic        rf_write_q, rf_write_d;
    logic [4:0]  rf_wraddr_q, rf_wraddr_d;
    logic [31:0] rf_wrdata_q, rf_wrdata_d;
    logic        misaligned_q, misaligned_d;
    logic [63:0] instret_q, instret_d;
    logic        take, done;
    logic [4:0]  done_rd;
    logic [31:0] done_data, result;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = w[16*off[1] +: 16];
        extract = (f3 == 3'b000) ? {{24{b[7]}}, b} :
                  (f3 == 3'b100) ? {24'd0, b} :
                  (f3 == 3'b001) ? {{16{h[15]}}, h} :
                  (f3 == 3'b101) ? {16'd0, h} : w;
    endfunction

    // Byte loads are always aligned; unknown funct3 values behave as LW.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        is_misaligned = (f3 == 3'b000 || f3 == 3'b100) ? 1'b0 :
                        (f3 == 3'b001 || f3 == 3'b101) ? off[0] : (off != 2'd0);
    endfunction

    assign in_ready = (state_q == RUN);

    always_comb begin
        take         = in_ready && in_valid && !flush;
        result       = (in_sel == 2'd0) ? in_alu : (in_sel == 2'd2) ? in_pc4 : in_imm;
        state_d      = state_q;
        ld_rd_d      = ld_rd_q;
        ld_f3_d      = ld_f3_q;
        ld_off_d     = ld_off_q;
        misaligned_d = 1'b0;
        done         = 1'b0;
        done_rd      = in_rd;
        done_data    = result;
        if (state_q == RUN) begin
            if (take) begin
                if (in_sel != 2'd1) begin
                    done = 1'b1;
                end else if (is_misaligned(in_funct3, in_addr_lo)) begin
                    misaligned_d = 1'b1;
                end else if (mem_rvalid) begin
                    done      = 1'b1;
                    done_data = extract(in_funct3, in_addr_lo, mem_rdata);
                end else begin
                    state_d  = WAIT_LD;
                    ld_rd_d  = in_rd;
                    ld_f3_d  = in_funct3;
                    ld_off_d = in_addr_lo;
                end
            end
        end else if (flush) begin
            state_d = RUN;
        end else if (mem_rvalid) begin
            state_d   = RUN;
            done      = 1'b1;
            done_rd   = ld_rd_q;
            done_data = extract(ld_f3_q, ld_off_q, mem_rdata);
        end
        rf_write_d  = done && (done_rd != 5'd0);
        rf_wraddr_d = done ? done_rd : rf_wraddr_q;
        rf_wrdata_d = done ? done_data : rf_wrdata_q;
        instret_d   = !INSTRET_EN ? 64'd0 : done ? instret_q + 64'd1 : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            ld_rd_q      <= '0;
            ld_f3_q      <= '0;
            ld_off_q     <= '0;
            rf_write_q   <= 1'b0;
            rf_wraddr_q  <= '0;
            rf_wrdata_q  <= '0;
            misaligned_q <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            ld_rd_q      <= ld_rd_d;
            ld_f3_q      <= ld_f3_d;
            ld_off_q     <= ld_off_d;
            rf_write_q   <= rf_write_d;
            rf_wraddr_q  <= rf_wraddr_d;
            rf_wrdata_q  <= rf_wrdata_d;
            misaligned_q <= misaligned_d;
            instret_q    <= instret_d;
        end
    end

    assign rf_write   = rf_write_q;
    assign rf_wrAddr  = rf_wraddr_q;
    assign rf_wrData  = rf_wrdata_q;
    assign misaligned = misaligned_q;
    assign instret    = instret_q;
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the pipeline. Accepts retiring instructions from the memory stage over a valid/ready handshake, selects the result source, aligns and sign-extends load data arriving with variable latency, and drives the register file's write port (`write`, `wrAddr`, `wrData`) from registered outputs. Also keeps the 64-bit retired-instruction counter and flags misaligned loads.

## Interface
- `INSTRET_EN`, default 1: 1 enables the `instret` counter; 0 holds `instret` at 0.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  stage can accept; transfer when `in_valid & in_ready`.
- `in_rd`  in  5  destination register.
- `in_sel`  in  2  result source: 0 ALU, 1 LOAD, 2 PC+4, 3 IMM.
- `in_alu`, `in_pc4`, `in_imm`  in  32 each  candidate results.
- `in_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other values are treated as LW.
- `in_addr_lo`  in  2  load byte offset.
- `flush`  in  1  kill any accepted-but-unwritten load; drop same-cycle acceptance.
- `mem_rvalid`  in  1  load data valid, one-cycle pulse.
- `mem_rdata`  in  32  raw word from data memory.
- `rf_write`  out  1  register-file write enable. Never 1 when `rf_wrAddr` is 0.
- `rf_wrAddr`  out  5  register-file write address.
- `rf_wrData`  out  32  register-file write data.
- `misaligned`  out  1  one-cycle pulse: misaligned load dropped.
- `instret`  out  64  retired-instruction count.

## Operation
- FSM has two states: RUN and WAIT_LD.
  - `in_ready` = 1 in RUN.
  - `in_ready` = 0 in WAIT_LD.
- In RUN, on a non-load transfer (`in_sel` ≠ 1):
  - Register the result into `rf_wrData` and `in_rd` into `rf_wrAddr`.
  - `rf_write` = (`in_rd` ≠ 0).
  - Increment `instret`.
- In RUN, on a load transfer:
  - Check alignment first. LH/LHU with odd `in_addr_lo`, or LW with `in_addr_lo` ≠ 0, is misaligned.
  - Misaligned load: pulse `misaligned` next cycle, no write, no retire, stay in RUN. `mem_rvalid` for it is ignored.
  - Aligned load with `mem_rvalid` = 1 in the same cycle: complete immediately, exactly like a non-load transfer.
  - Aligned load otherwise: latch rd/funct3/offset and go to WAIT_LD.
- In WAIT_LD:
  - On `mem_rvalid`: write the extracted data, retire, return to RUN.
  - `flush` (with or without `mem_rvalid`) returns to RUN with no write and no retire.
- Load extraction:
  - Byte = `mem_rdata[8*off +: 8]`. Half = `mem_rdata[16*off[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `flush` in RUN with `in_valid` set: no transfer takes effect (no write, no retire, no misaligned pulse).
- `mem_rvalid` in RUN with no load transfer is ignored.
- Writes to x0: `rf_write` stays 0 but the instruction still retires.
- `instret` wraps from 2^64−1 to 0.

## Timing
- Reset values: `rf_write` 0, `rf_wrAddr` 0, `rf_wrData` 0, `misaligned` 0, `instret` 0, state RUN (so `in_ready` = 1).
- Latency is 1 cycle from completing event to outputs:
  - Non-load or same-cycle load: transfer at edge N → `rf_write` high during cycle N+1.
  - Waited load: `mem_rvalid` at edge M → `rf_write` high during cycle M+1.
  - `instret` updates at the same edge that raises `rf_write`.
- `rf_write` and `misaligned` are single-cycle pulses. `rf_wrAddr` and `rf_wrData` hold their values until the next write.
- Back-to-back non-loads sustain one write per cycle.
- Each waited load blocks acceptance until the cycle after `mem_rvalid`.
- `in_ready` is a combinational decode of the state register only. It does not depend on `in_valid`, `flush` or `mem_rvalid`.
- Asserting `rst_n` low mid-WAIT_LD immediately clears state and outputs. Any later `mem_rvalid` is ignored.

## Test plan
- ALU back-to-back: three transfers, ALU results 0x11, 0x22, 0x33 to rd 1, 2, 3 on consecutive cycles → `rf_write` high for 3 consecutive cycles with those addresses and data; `instret` = 3.
- Load with 2-cycle wait: LB, offset 2, `mem_rdata` = 0x0080_0000, rd 5, `mem_rvalid` two cycles after transfer → `in_ready` low for 2 cycles; write 0xFFFF_FF80 to x5 one cycle after `mem_rvalid`. Repeat with LBU → 0x0000_0080.
- Same-cycle load: LHU, offset 2, `mem_rdata` = 0xBEEF_1234, `mem_rvalid` with transfer → no stall; write 0x0000_BEEF next cycle.
- Misaligned: LW, offset 1 → `misaligned` pulses once; `rf_write` stays 0; `instret` unchanged; next instruction accepted the following cycle.
- x0 and flush: ALU to rd 0 → no write, `instret` +1. Then load → WAIT_LD; `flush` together with `mem_rvalid` → no write, `instret` unchanged, `in_ready` = 1 next cycle.
- Reset mid-wait: `rst_n` low in WAIT_LD, later `mem_rvalid` → all outputs 0, no write.
